// File: rtl/ssp_frame_ctrl.sv
// ssp_frame_ctrl: TI synchronous-serial frame sequencer in the PCLK domain.
// It pops words from the transmit FIFO and emits a one-bit-period frame
// sync followed by DATA_W data bits, MSB first. It also assembles received
// bits into words for the receive FIFO. Every output is a flop.
module ssp_frame_ctrl #(
    parameter int DATA_W = 8,   // bits per frame, 4..16
    parameter int DIV    = 4    // PCLK cycles per serial bit, even, >= 2
) (
    input  logic              PCLK,
    input  logic              CLEAR_B,
    input  logic              TX_VALID,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_POP,
    input  logic              RX_READY,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_VALID,
    output logic              RX_OVR,
    output logic              SSPCLKOUT,
    output logic              SSPFSSOUT,
    output logic              SSPTXD,
    input  logic              SSPRXD,
    output logic              SSPOE_B,
    output logic              BUSY
);

    localparam int PW = $clog2(DIV);
    localparam int BW = $clog2(DATA_W);

    // Phase values inside one serial bit period.
    localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HALF   = PW'(DIV / 2);
    localparam logic [PW-1:0] P_SAMPLE = PW'(DIV / 2 - 1);
    localparam logic [BW-1:0] B_FIRST  = BW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SHIFT
    } state_t;

    state_t            state;
    logic [PW-1:0]     p;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    logic              frame_end;
    logic              load;
    logic [PW-1:0]     p_next;
    logic              clk_next;

    // Decode the frame boundary and the next phase value.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        frame_end = 1'b0;
        load      = 1'b0;
        p_next    = '0;
        clk_next  = 1'b0;

        frame_end = (state == SHIFT) && (p == P_LAST) && (bit_cnt == '0);
        // A word is taken only while IDLE or on the end-of-frame edge.
        load      = TX_VALID && ((state == IDLE) || frame_end);
        p_next    = (p == P_LAST) ? '0 : p + PW'(1);
        clk_next  = (p_next < P_HALF);
    end

    // Frame sequencer: state, counters, shift registers and all registered outputs.
    always_ff @(posedge PCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values, whatever the statement order.
        TX_POP   <= 1'b0;
        RX_VALID <= 1'b0;
        RX_OVR   <= 1'b0;

        if (CLEAR_B) begin
            state     <= IDLE;
            p         <= '0;
            bit_cnt   <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            RX_DATA   <= '0;
            SSPCLKOUT <= 1'b0;
            SSPFSSOUT <= 1'b0;
            SSPTXD    <= 1'b0;
            SSPOE_B   <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            // Capture SSPRXD on the edge that ends the high half of SSPCLKOUT.
            if ((state == SHIFT) && (p == P_SAMPLE)) begin
                rx_sr <= {rx_sr[DATA_W-2:0], SSPRXD};
            end

            // Deliver the word, or flag it as dropped, whether or not another frame follows.
            if (frame_end) begin
                if (RX_READY) begin
                    RX_DATA  <= rx_sr;
                    RX_VALID <= 1'b1;
                end else begin
                    RX_OVR   <= 1'b1;
                end
            end

            if (load) begin
                // Start a frame: sync phase, bit period 0, MSB already on the line.
                state     <= SYNC;
                p         <= '0;
                tx_sr     <= TX_DATA;
                TX_POP    <= 1'b1;
                SSPCLKOUT <= 1'b1;
                SSPFSSOUT <= 1'b1;
                SSPTXD    <= TX_DATA[DATA_W-1];
                SSPOE_B   <= 1'b0;
                BUSY      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        p         <= '0;
                        SSPCLKOUT <= 1'b0;
                        SSPFSSOUT <= 1'b0;
                        SSPTXD    <= 1'b0;
                        SSPOE_B   <= 1'b1;
                        BUSY      <= 1'b0;
                    end

                    SYNC: begin
                        p         <= p_next;
                        SSPCLKOUT <= clk_next;
                        if (p == P_LAST) begin
                            // MSB stays on SSPTXD; only the frame sync drops.
                            state     <= SHIFT;
                            bit_cnt   <= B_FIRST;
                            SSPFSSOUT <= 1'b0;
                        end
                    end

                    SHIFT: begin
                        if (frame_end) begin
                            state     <= IDLE;
                            p         <= '0;
                            SSPCLKOUT <= 1'b0;
                            SSPFSSOUT <= 1'b0;
                            SSPTXD    <= 1'b0;
                            SSPOE_B   <= 1'b1;
                            BUSY      <= 1'b0;
                        end else begin
                            p         <= p_next;
                            SSPCLKOUT <= clk_next;
                            if (p == P_LAST) begin
                                // Data moves only as the bit period wraps.
                                bit_cnt <= bit_cnt - BW'(1);
                                tx_sr   <= tx_sr << 1;
                                SSPTXD  <= tx_sr[DATA_W-2];
                            end
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssp_frame_ctrl.sv
// tb_ssp_frame_ctrl: randomized and directed self-checking bench.
// Two instances share all stimulus: DIV=4 and DIV=2, both with DATA_W=8.
// The reference model tracks each frame as an offset k from its start cycle
// and derives every expected output from that offset with plain arithmetic.
module tb_ssp_frame_ctrl;

    localparam int DATA_W = 8;

    logic PCLK = 1'b0;
    logic CLEAR_B;
    logic TX_VALID;
    logic [DATA_W-1:0] TX_DATA;
    logic RX_READY;
    logic loop_en;
    logic rxd_rand;

    logic [1:0] tx_pop, rx_valid, rx_ovr, sspclk, sspfss, ssptxd, ssprxd, sspoe_b, busy;
    logic [DATA_W-1:0] rx_data_o [2];
    logic [7:0] outs [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model state, one slot per instance.
    int              divs [2] = '{4, 2};
    bit              m_busy [2];
    int              m_k [2];
    logic [DATA_W-1:0] m_word [2];
    logic [DATA_W-1:0] m_acc [2];
    logic [DATA_W-1:0] m_rxd [2];
    bit              m_rxv [2];
    bit              m_ovr [2];

    always #5 PCLK = ~PCLK;

    assign ssprxd[0] = loop_en ? ssptxd[0] : rxd_rand;
    assign ssprxd[1] = loop_en ? ssptxd[1] : rxd_rand;

    assign outs[0] = {tx_pop[0], rx_valid[0], rx_ovr[0], sspclk[0], sspfss[0], ssptxd[0], sspoe_b[0], busy[0]};
    assign outs[1] = {tx_pop[1], rx_valid[1], rx_ovr[1], sspclk[1], sspfss[1], ssptxd[1], sspoe_b[1], busy[1]};

    ssp_frame_ctrl #(.DATA_W(DATA_W), .DIV(4)) dut0 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
        .TX_POP(tx_pop[0]), .RX_READY(RX_READY), .RX_DATA(rx_data_o[0]),
        .RX_VALID(rx_valid[0]), .RX_OVR(rx_ovr[0]), .SSPCLKOUT(sspclk[0]),
        .SSPFSSOUT(sspfss[0]), .SSPTXD(ssptxd[0]), .SSPRXD(ssprxd[0]),
        .SSPOE_B(sspoe_b[0]), .BUSY(busy[0])
    );

    ssp_frame_ctrl #(.DATA_W(DATA_W), .DIV(2)) dut1 (
        .PCLK(PCLK), .CLEAR_B(CLEAR_B), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
        .TX_POP(tx_pop[1]), .RX_READY(RX_READY), .RX_DATA(rx_data_o[1]),
        .RX_VALID(rx_valid[1]), .RX_OVR(rx_ovr[1]), .SSPCLKOUT(sspclk[1]),
        .SSPFSSOUT(sspfss[1]), .SSPTXD(ssptxd[1]), .SSPRXD(ssprxd[1]),
        .SSPOE_B(sspoe_b[1]), .BUSY(busy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Serial data the model expects on SSPTXD this cycle.
    function automatic logic exp_txd(input int i);
        int div = divs[i];
        if (!m_busy[i]) return 1'b0;
        if (m_k[i] < div) return m_word[i][DATA_W-1];
        return m_word[i][DATA_W-1-(m_k[i]/div-1)];
    endfunction

    // {pop, rx_valid, rx_ovr, sclk, fss, txd, oe_b, busy} expected this cycle.
    function automatic logic [7:0] exp_outs(input int i);
        int div = divs[i];
        if (!m_busy[i]) return {1'b0, m_rxv[i], m_ovr[i], 5'b00010};
        return {(m_k[i] == 0), m_rxv[i], m_ovr[i], ((m_k[i] % div) < div/2),
                (m_k[i] < div), exp_txd(i), 1'b0, 1'b1};
    endfunction

    // Check the current cycle, advance the model across the coming edge, then step.
    task automatic cycle(input bit chk);
        if (chk) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("outs%0d {pop,rxv,ovr,clk,fss,txd,oe_b,busy}", i), outs[i], exp_outs(i));
                check($sformatf("rx_data%0d", i), rx_data_o[i], m_rxd[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            int div = divs[i];
            int f = (DATA_W + 1) * divs[i];
            logic rbit;
            rbit = loop_en ? exp_txd(i) : rxd_rand;
            m_rxv[i] = 1'b0;
            m_ovr[i] = 1'b0;
            if (CLEAR_B) begin
                m_busy[i] = 1'b0;
                m_k[i]    = 0;
                m_rxd[i]  = '0;
            end else if (m_busy[i]) begin
                if (m_k[i] >= div && (m_k[i] % div) == div/2 - 1)
                    m_acc[i] = {m_acc[i][DATA_W-2:0], rbit};
                if (m_k[i] == f - 1) begin
                    if (RX_READY) begin
                        m_rxv[i] = 1'b1;
                        m_rxd[i] = m_acc[i];
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                    if (TX_VALID) begin
                        m_word[i] = TX_DATA;
                        m_k[i]    = 0;
                    end else begin
                        m_busy[i] = 1'b0;
                    end
                end else begin
                    m_k[i]++;
                end
            end else if (TX_VALID) begin
                m_busy[i] = 1'b1;
                m_k[i]    = 0;
                m_word[i] = TX_DATA;
            end
        end
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) cycle(1'b1);
    endtask

    task automatic send_one(input logic [DATA_W-1:0] w);
        TX_VALID = 1'b1;
        TX_DATA  = w;
        cycle(1'b1);
        TX_VALID = 1'b0;
        TX_DATA  = $urandom;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((m_busy[0] || m_busy[1]) && n < bound) begin
            cycle(1'b1);
            n++;
        end
        run(2);
        if (m_busy[0] || m_busy[1]) begin
            n_checks++;
            n_errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, required idle", bound);
        end
    endtask

    initial begin
        CLEAR_B  = 1'b1;
        TX_VALID = 1'b0;
        TX_DATA  = '0;
        RX_READY = 1'b1;
        loop_en  = 1'b1;
        rxd_rand = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_acc[i]  = '0;
            m_word[i] = '0;
        end
        @(posedge PCLK);
        #1;
        cycle(1'b0);
        CLEAR_B = 1'b0;

        // Idle hold: no pop, no clock, output disabled.
        run(100);

        // Single word, loopback.
        send_one(8'hA5);
        wait_idle(100);
        check("s1_rx_data0", rx_data_o[0], 8'hA5);
        check("s1_rx_data1", rx_data_o[1], 8'hA5);

        // Back-to-back frames: TX_VALID held across the end-of-frame edge.
        TX_VALID = 1'b1;
        TX_DATA  = 8'h3C;
        cycle(1'b1);
        TX_DATA  = 8'hC3;
        run(36);
        TX_VALID = 1'b0;
        wait_idle(200);
        check("s2_rx_data0", rx_data_o[0], 8'hC3);

        // Receive overrun: the previous word must survive.
        RX_READY = 1'b0;
        send_one(8'h5A);
        wait_idle(100);
        RX_READY = 1'b1;
        check("s3_rx_hold0", rx_data_o[0], 8'hC3);
        check("s3_rx_hold1", rx_data_o[1], 8'hC3);

        // Reset during data bit 4 of the DIV=4 frame.
        send_one(8'hE7);
        run(4 + 4 * 4 + 1);
        CLEAR_B = 1'b1;
        cycle(1'b1);
        CLEAR_B = 1'b0;
        check("s4_rx_cleared0", rx_data_o[0], 8'h00);
        check("s4_oe_b0", sspoe_b[0], 1'b1);
        send_one(8'h81);
        wait_idle(100);
        check("s4_rx_data0", rx_data_o[0], 8'h81);

        // All-zero transmit with SSPRXD tied high.
        loop_en  = 1'b0;
        rxd_rand = 1'b1;
        send_one(8'h00);
        wait_idle(100);
        check("s5_rx_data0", rx_data_o[0], 8'hFF);
        check("s5_rx_data1", rx_data_o[1], 8'hFF);
        loop_en = 1'b1;

        // Randomized traffic, backpressure, serial input and occasional resets.
        for (int j = 0; j < 3000; j++) begin
            TX_VALID = ($urandom_range(0, 99) < 30);
            TX_DATA  = $urandom;
            RX_READY = ($urandom_range(0, 9) != 0);
            rxd_rand = $urandom;
            CLEAR_B  = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 199) == 0) loop_en = ~loop_en;
            cycle(1'b1);
        end
        CLEAR_B  = 1'b0;
        TX_VALID = 1'b0;
        RX_READY = 1'b1;
        wait_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
